// File: rtl/down_timer.sv
// ---------------------------------------------------------------------------
// down_timer
//   Programmable down-counting timer with reload. A load captures a start
//   value; while running, each enabled cycle decrements the count. Reaching
//   terminal count (1 -> next) raises a registered one-cycle expire pulse and
//   either restarts from the stored reload value (AUTO_RELOAD=1) or stops
//   (AUTO_RELOAD=0).
//
//   state | meaning
//   ------+-----------------------------------------------
//   IDLE  | count holds (0 after reset/stop), en ignored
//   RUN   | counting down on en, busy high
//
// Parameters
//   W           counter / load-value width (W >= 4)
//   AUTO_RELOAD 1: restart from reload value on expiry, 0: stop on expiry
//
// Ports
//   clk         sole clock, rising edge
//   rst_n       asynchronous active-low reset
//   load_valid  load request (highest priority)
//   load_value  start / reload value
//   en          decrement enable
//   stop        abort back to IDLE (below load in priority)
//   count       current count
//   busy        high while in RUN (decoded from state)
//   expire      one-cycle terminal-count pulse
// ---------------------------------------------------------------------------
module down_timer #(
    parameter int W           = 10,
    parameter bit AUTO_RELOAD = 1'b1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load_valid,
    input  logic [W-1:0] load_value,
    input  logic         en,
    input  logic         stop,
    output logic [W-1:0] count,
    output logic         busy,
    output logic         expire
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t         state_q, state_d;
    logic [W-1:0]   count_q, count_d;
    logic [W-1:0]   reload_q, reload_d;
    logic           expire_q, expire_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            count_q  <= '0;
            reload_q <= '0;
            expire_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            reload_q <= reload_d;
            expire_q <= expire_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        reload_d = reload_q;
        expire_d = 1'b0;

        if (load_valid) begin
            reload_d = load_value;
            count_d  = load_value;
            // A zero load parks the timer rather than running into an underflow.
            state_d  = (load_value != '0) ? RUN : IDLE;
        end else if (stop) begin
            count_d = '0;
            state_d = IDLE;
        end else if (state_q == RUN && en) begin
            if (count_q == W'(1)) begin
                expire_d = 1'b1;
                if (AUTO_RELOAD) begin
                    count_d = reload_q;
                end else begin
                    count_d = '0;
                    state_d = IDLE;
                end
            end else begin
                // RUN never holds 0, so this only ever decrements from >= 2.
                count_d = count_q - W'(1);
            end
        end
    end

    assign count  = count_q;
    assign busy   = (state_q == RUN);
    assign expire = expire_q;

`ifndef SYNTHESIS
    ap_busy_nonzero : assert property (@(posedge clk) disable iff (!rst_n)
        busy |-> (count_q != '0));

    ap_busy_le_reload : assert property (@(posedge clk) disable iff (!rst_n)
        busy |-> (count_q <= reload_q));

    ap_expire_from_one : assert property (@(posedge clk) disable iff (!rst_n)
        expire |-> ($past(count_q) == W'(1)));

    ap_busy_fall_cause : assert property (@(posedge clk) disable iff (!rst_n)
        !busy |-> (!$past(busy) || $past(stop || load_valid || (count_q == W'(1)))));

    cp_expire : cover property (@(posedge clk) disable iff (!rst_n) expire);
`endif

endmodule
